// File: rtl/roi_crop_engine.sv
// Streams a full raster frame in and forwards only the beats inside a PPB-aligned
// crop window, tracking the min/max pixel seen inside the window.
module roi_crop_engine #(
    parameter int IN_ROWS  = 64,
    parameter int IN_COLS  = 64,
    parameter int OUT_ROWS = 32,
    parameter int OUT_COLS = 32,
    parameter int PIX_W    = 8,
    parameter int PPB      = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_idle,
    output logic                        ap_done,
    input  logic [$clog2(IN_COLS)-1:0]  crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0]  crop_y0,
    output logic                        cfg_err,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [PPB*PIX_W-1:0]        s_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [PPB*PIX_W-1:0]        m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic [PIX_W-1:0]            max_value,
    output logic [PIX_W-1:0]            min_value,
    output logic                        stats_valid
);

    localparam int XW = $clog2(IN_COLS);
    localparam int YW = $clog2(IN_ROWS);
    localparam int DW = PPB * PIX_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic [XW-1:0] col, x0_q;
    logic [YW-1:0] row, y0_q;

    logic [DW-1:0] fifo_data [2];
    logic          fifo_user [2];
    logic          fifo_last [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_count;

    logic start_legal, start_accept, start_reject;
    logic in_box, is_first, is_row_end, is_last_beat;
    logic beat_accept, push, pop;
    logic [PIX_W-1:0] beat_max, beat_min;
    int row_i, col_i, x_i, y_i, cx_i, cy_i;

    always_comb begin
        cx_i = int'(crop_x0);
        cy_i = int'(crop_y0);
        start_legal  = ((cx_i % PPB) == 0) && (cx_i + OUT_COLS <= IN_COLS)
                       && (cy_i + OUT_ROWS <= IN_ROWS);
        start_accept = (state == IDLE) && ap_start && start_legal;
        start_reject = (state == IDLE) && ap_start && !start_legal;

        row_i = int'(row);
        col_i = int'(col);
        x_i   = int'(x0_q);
        y_i   = int'(y0_q);
        in_box = (row_i >= y_i) && (row_i < y_i + OUT_ROWS)
                 && (col_i >= x_i) && (col_i < x_i + OUT_COLS);
        is_first     = (row_i == y_i) && (col_i == x_i);
        is_row_end   = (col_i == x_i + OUT_COLS - PPB);
        is_last_beat = (row_i == IN_ROWS - 1) && (col_i == IN_COLS - PPB);
    end

    // Out-of-box beats are always swallowed; in-box beats wait for FIFO room.
    assign s_axis_tready = (state == RUN) && (!in_box || (fifo_count != 2'd2));
    assign beat_accept   = s_axis_tvalid && s_axis_tready;
    assign push          = beat_accept && in_box;
    assign pop           = m_axis_tvalid && m_axis_tready;

    assign ap_ready = (state == IDLE);
    assign ap_idle  = (state == IDLE);
    assign ap_done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start_accept) next_state = RUN;
            RUN:   if (beat_accept && is_last_beat) next_state = DRAIN;
            DRAIN: if (fifo_count == 2'd0) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            row  <= '0;
            col  <= '0;
            x0_q <= '0;
            y0_q <= '0;
        end else if (start_accept) begin
            row  <= '0;
            col  <= '0;
            x0_q <= crop_x0;
            y0_q <= crop_y0;
        end else if (beat_accept) begin
            if (col_i == IN_COLS - PPB) begin
                col <= '0;
                row <= row + YW'(1);
            end else begin
                col <= col + XW'(PPB);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= s_axis_tdata;
            fifo_user[wr_ptr] <= is_first;
            fifo_last[wr_ptr] <= is_row_end;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = fifo_data[rd_ptr];
    assign m_axis_tuser  = m_axis_tvalid && fifo_user[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];

    always_comb begin
        logic [PIX_W-1:0] lane;
        beat_max = '0;
        beat_min = '1;
        lane     = '0;
        for (int i = 0; i < PPB; i++) begin
            lane = s_axis_tdata[i*PIX_W +: PIX_W];
            if (lane > beat_max) beat_max = lane;
            if (lane < beat_min) beat_min = lane;
        end
    end

    // Rejected starts must leave the previous frame's statistics untouched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            max_value   <= '0;
            min_value   <= '1;
            stats_valid <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= start_reject;
            if (start_accept) begin
                max_value   <= '0;
                min_value   <= '1;
                stats_valid <= 1'b0;
            end else begin
                if (push) begin
                    if (beat_max > max_value) max_value <= beat_max;
                    if (beat_min < min_value) min_value <= beat_min;
                end
                if (state == DONE) stats_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_roi_crop_engine.sv
// Table-driven frame tests for roi_crop_engine with a scoreboard of expected
// output beats, on an 8x8 frame cropped to 4x4 with two pixels per beat.
module tb_roi_crop_engine;

    localparam int IN_ROWS  = 8;
    localparam int IN_COLS  = 8;
    localparam int OUT_ROWS = 4;
    localparam int OUT_COLS = 4;
    localparam int PIX_W    = 8;
    localparam int PPB      = 2;
    localparam int DW       = PPB * PIX_W;
    localparam int BPR      = IN_COLS / PPB;
    localparam int NBEATS   = IN_ROWS * BPR;
    localparam int OUT_BEATS = OUT_ROWS * OUT_COLS / PPB;

    logic clk;
    logic resetn;
    logic ap_start, ap_ready, ap_idle, ap_done;
    logic [2:0] crop_x0, crop_y0;
    logic cfg_err;
    logic s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic m_axis_tvalid, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic m_axis_tuser, m_axis_tlast;
    logic [PIX_W-1:0] max_value, min_value;
    logic stats_valid;

    roi_crop_engine #(
        .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .OUT_ROWS(OUT_ROWS),
        .OUT_COLS(OUT_COLS), .PIX_W(PIX_W), .PPB(PPB)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
        .crop_x0(crop_x0), .crop_y0(crop_y0), .cfg_err(cfg_err),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .max_value(max_value), .min_value(min_value), .stats_valid(stats_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x0;
        int y0;
        int mode;
        bit mid_start;
        int abort_at;
        bit exp_err;
        int exp_max;
        int exp_min;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int asserts = 0;
    int fails   = 0;
    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] beatData(input int b);
        int r, c;
        logic [7:0] p0, p1;
        r  = b / BPR;
        c  = (b % BPR) * PPB;
        p0 = 8'(r * IN_COLS + c);
        p1 = 8'(r * IN_COLS + c + 1);
        return {p1, p0};
    endfunction

    function automatic bit inBox(input int b, input int x0, input int y0);
        int r, c;
        r = b / BPR;
        c = (b % BPR) * PPB;
        return (r >= y0) && (r < y0 + OUT_ROWS) && (c >= x0) && (c < x0 + OUT_COLS);
    endfunction

    task automatic checkResetState();
        checkOutput("rst_ap_done", ap_done, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_s_tready", s_axis_tready, 0);
        checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
        checkOutput("rst_m_tuser", m_axis_tuser, 0);
        checkOutput("rst_m_tlast", m_axis_tlast, 0);
        checkOutput("rst_max", max_value, 0);
        checkOutput("rst_min", min_value, 255);
        checkOutput("rst_stats_valid", stats_valid, 0);
        checkOutput("rst_ap_ready", ap_ready, 1);
        checkOutput("rst_ap_idle", ap_idle, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int b = 0;
        int done_cnt = 0;
        int out_cnt = 0;
        bit finished = 0;
        bit mid_done = 0;
        bit ib;
        logic prev_sv;
        logic [PIX_W-1:0] prev_max, prev_min;
        exp_t e;
        int r, c;

        prev_sv  = stats_valid;
        prev_max = max_value;
        prev_min = min_value;

        @(negedge clk);
        crop_x0       = 3'(v.x0);
        crop_y0       = 3'(v.y0);
        ap_start      = 1'b1;
        s_axis_tvalid = v.exp_err;
        s_axis_tdata  = beatData(0);
        m_axis_tready = 1'b1;
        #1;
        checkOutput("ap_ready_at_start", ap_ready, 1);

        if (v.exp_err) begin
            checkOutput("s_tready_idle", s_axis_tready, 0);
            @(negedge clk);
            ap_start = 1'b0;
            #1;
            checkOutput("cfg_err_pulse", cfg_err, 1);
            checkOutput("idle_after_err", ap_idle, 1);
            checkOutput("s_tready_after_err", s_axis_tready, 0);
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            #1;
            checkOutput("cfg_err_one_cycle", cfg_err, 0);
            checkOutput("stats_valid_kept", stats_valid, prev_sv);
            checkOutput("max_kept", max_value, prev_max);
            checkOutput("min_kept", min_value, prev_min);
            return;
        end

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            ap_start = 1'b0;
            if (v.mid_start && b == 5 && !mid_done) begin
                ap_start = 1'b1;
                crop_x0  = 3'd0;
                crop_y0  = 3'd0;
                mid_done = 1'b1;
            end
            s_axis_tvalid = (b < NBEATS);
            s_axis_tdata  = beatData(b < NBEATS ? b : 0);
            m_axis_tready = (v.mode == 0) ? 1'b1 : ((cyc % 4) == 0);
            #1;
            ib = (b < NBEATS) && inBox(b, v.x0, v.y0);
            if (cyc == 0) begin
                checkOutput("stats_valid_cleared", stats_valid, 0);
                checkOutput("max_cleared", max_value, 0);
                checkOutput("min_cleared", min_value, 255);
            end
            checkOutput("s_tready", s_axis_tready, (b < NBEATS) && (!ib || sb.size() < 2));
            checkOutput("m_tvalid", m_axis_tvalid, sb.size() != 0);
            if (ap_done) begin
                done_cnt++;
                finished = 1'b1;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("m_tdata", m_axis_tdata, e.data);
                    checkOutput("m_tuser", m_axis_tuser, e.user);
                    checkOutput("m_tlast", m_axis_tlast, e.last);
                    out_cnt++;
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (ib) begin
                    r = b / BPR;
                    c = (b % BPR) * PPB;
                    e.data = beatData(b);
                    e.user = (r == v.y0) && (c == v.x0);
                    e.last = (c == v.x0 + OUT_COLS - PPB);
                    sb.push_back(e);
                end
                b++;
                if (v.abort_at > 0 && b == v.abort_at) break;
            end
        end

        if (v.abort_at > 0) begin
            @(negedge clk);
            resetn        = 1'b0;
            s_axis_tvalid = 1'b0;
            m_axis_tready = 1'b0;
            ap_start      = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            #1;
            checkOutput("abort_beats_in", b, v.abort_at);
            checkResetState();
            checkOutput("no_done_on_abort", done_cnt, 0);
            sb.delete();
            return;
        end

        if (!finished) checkOutput("frame_timeout", 0, 1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #1;
        checkOutput("done_count", done_cnt, 1);
        checkOutput("done_one_cycle", ap_done, 0);
        checkOutput("idle_after_done", ap_idle, 1);
        checkOutput("stats_valid_set", stats_valid, 1);
        checkOutput("max_value", max_value, v.exp_max);
        checkOutput("min_value", min_value, v.exp_min);
        checkOutput("out_beats", out_cnt, OUT_BEATS);
        checkOutput("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        //          x0 y0 mode mid abort err max min
        vecs[0] = '{2, 3, 0, 0, 0,  0, 53, 26};
        vecs[1] = '{3, 0, 0, 0, 0,  1, 0,  0};
        vecs[2] = '{6, 0, 0, 0, 0,  1, 0,  0};
        vecs[3] = '{0, 5, 0, 0, 0,  1, 0,  0};
        vecs[4] = '{2, 3, 1, 0, 0,  0, 53, 26};
        vecs[5] = '{2, 3, 0, 1, 0,  0, 53, 26};
        vecs[6] = '{4, 4, 1, 0, 0,  0, 63, 36};
        vecs[7] = '{2, 3, 0, 0, 20, 0, 0,  0};
        vecs[8] = '{0, 0, 0, 0, 0,  0, 27, 0};

        resetn        = 1'b0;
        ap_start      = 1'b0;
        crop_x0       = 3'd0;
        crop_y0       = 3'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        checkResetState();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
